serial_add_sched: RTL and testbench

//  Bit-serial add/subtract engine shared by NREQ requesters (e.g. per-channel
//  NCO/accumulator updates). Round-robin arbiter grants one requester, latches
//  its operands, then drives one full-adder cell plus a carry flop for W cycles,
//  LSB first. Trades W cycles of latency per operation for one adder's area.

---
 rtl/gps_arith_pkg.sv | 27 ++
 rtl/serial_add_sched_if.sv | 31 +++
 rtl/fa_cell.sv | 11 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/serial_add_sched.sv | 124 ++++++++++++
 tb/tb_serial_add_sched.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/gps_arith_pkg.sv
// rtl/gps_arith_pkg.sv - shared types and helpers for the bit-serial arithmetic engine
package gps_arith_pkg;

   localparam int DEFAULT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   // Bits needed to hold values 0..n-1 (at least 1 bit)
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// rtl/serial_add_sched_if.sv - requester-side bundle of the shared serial adder
interface serial_add_sched_if
   import gps_arith_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = DEFAULT_W
);
   localparam int IDW = clog2(NREQ);

   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   sub;
   logic [NREQ*W-1:0] a;
   logic [NREQ*W-1:0] b;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              done;
   logic [IDW-1:0]    done_id;
   logic [W-1:0]      sum;
   logic              cout;
   logic              ovf;

   modport master (
      output req, sub, a, b,
      input  gnt, busy, done, done_id, sum, cout, ovf
   );

   modport slave (
      input  req, sub, a, b,
      output gnt, busy, done, done_id, sum, cout, ovf
   );
endinterface

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit full adder, the carry-chain primitive of the datapath
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter
   import gps_arith_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = clog2(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [IDW-1:0]  win_idx,
   output logic            any
);
   int  j;
   logic found;

   // Scan cyclically from ptr; the first set request wins
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!found && req[j]) begin
            found     = 1'b1;
            win_oh[j] = 1'b1;
            win_idx   = IDW'(j);
         end
      end
      any = found;
   end
endmodule

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - shared bit-serial add/subtract engine with round-robin scheduling
module serial_add_sched
   import gps_arith_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = DEFAULT_W
)(
   input  logic                clk,
   input  logic                rst_n,
   serial_add_sched_if.slave   bus
);
   localparam int IDW = clog2(NREQ);
   localparam int CW  = clog2(W);

   sched_state_t     state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win_r;
   logic [W-1:0]     op_a;      // holds A, result bits shift in from the top
   logic [W-1:0]     op_b;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [NREQ-1:0]  gnt_r;
   logic             busy_r;
   logic             done_r;
   logic [IDW-1:0]   done_id_r;
   logic [W-1:0]     sum_r;
   logic             cout_r;
   logic             ovf_r;

   logic [NREQ-1:0]  arb_oh;
   logic [IDW-1:0]   arb_idx;
   logic             arb_any;
   logic             fa_s;
   logic             fa_co;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (bus.req),
      .ptr     (ptr),
      .win_oh  (arb_oh),
      .win_idx (arb_idx),
      .any     (arb_any)
   );

   fa_cell u_fa (
      .a  (op_a[0]),
      .b  (op_b[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Scheduler FSM and serial datapath; all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         win_r     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         gnt_r     <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         done_id_r <= '0;
         sum_r     <= '0;
         cout_r    <= 1'b0;
         ovf_r     <= 1'b0;
      end else begin
         gnt_r  <= '0;
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  gnt_r  <= arb_oh;
                  win_r  <= arb_idx;
                  busy_r <= 1'b1;
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // Subtraction is a + ~b + 1: invert B and seed the carry
               op_a  <= bus.a[int'(win_r)*W +: W];
               op_b  <= bus.b[int'(win_r)*W +: W] ^ {W{bus.sub[win_r]}};
               carry <= bus.sub[win_r];
               cnt   <= '0;
               ptr   <= (win_r == IDW'(NREQ-1)) ? '0 : win_r + 1'b1;
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               carry <= fa_co;
               op_a  <= {fa_s, op_a[W-1:1]};
               op_b  <= {1'b0, op_b[W-1:1]};
               if (cnt == CW'(W-1)) begin
                  // carry here is the carry into the MSB; xor with carry out flags signed overflow
                  sum_r     <= {fa_s, op_a[W-1:1]};
                  cout_r    <= fa_co;
                  ovf_r     <= carry ^ fa_co;
                  done_id_r <= win_r;
                  done_r    <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.done_id = done_id_r;
   assign bus.sum     = sum_r;
   assign bus.cout    = cout_r;
   assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - self-checking bench for serial_add_sched
module tb_serial_add_sched;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_add_sched_if #(.NREQ(NREQ), .W(W)) sif ();

   serial_add_sched #(.NREQ(NREQ), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // returns {ovf, cout, sum}
   function automatic logic [W+1:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         o;
      bb   = s ? ~bv : bv;
      full = {1'b0, av} + {1'b0, bb} + (W+1)'(s);
      o    = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
      return {o, full};
   endfunction

   // ---------------- reference model + per-cycle compare ----------------
   logic [NREQ-1:0] prev_req = '0;
   logic            prev_rstn = 1'b0;
   int              cyc = 0;
   int              done_due = -100;
   int              gnt_cyc = -100;
   int              ptr_m = 0;
   int              m_id = 0;
   logic [W-1:0]    m_a, m_b;
   logic            m_s;
   logic [W-1:0]    e_sum = '0;
   logic            e_cout = 1'b0;
   logic            e_ovf = 1'b0;
   int              e_id = 0;

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_gnt;
      logic [W+1:0]    r;
      cyc++;
      if (!prev_rstn) begin
         done_due = -100;
         gnt_cyc  = -100;
         ptr_m    = 0;
         e_sum    = '0;
         e_cout   = 1'b0;
         e_ovf    = 1'b0;
         e_id     = 0;
         chk("rst_gnt",  sif.gnt,  '0);
         chk("rst_busy", sif.busy, 0);
         chk("rst_done", sif.done, 0);
         chk("rst_sum",  sif.sum,  0);
         chk("rst_flags", {sif.cout, sif.ovf, sif.done_id}, 0);
      end else begin
         exp_gnt = '0;
         if ((cyc - 1 > done_due) && (|prev_req)) begin
            m_id           = rr_pick(prev_req, ptr_m);
            exp_gnt[m_id]  = 1'b1;
            m_a            = sif.a[m_id*W +: W];
            m_b            = sif.b[m_id*W +: W];
            m_s            = sif.sub[m_id];
            ptr_m          = (m_id + 1) % NREQ;
            gnt_cyc        = cyc;
            done_due       = cyc + W + 1;
         end
         if (cyc == done_due) begin
            r      = ref_add(m_a, m_b, m_s);
            e_sum  = r[W-1:0];
            e_cout = r[W];
            e_ovf  = r[W+1];
            e_id   = m_id;
         end
         chk("gnt",     sif.gnt,  exp_gnt);
         chk("busy",    sif.busy, (cyc >= gnt_cyc) && (cyc <= done_due));
         chk("done",    sif.done, cyc == done_due);
         chk("sum",     sif.sum,  e_sum);
         chk("cout",    sif.cout, e_cout);
         chk("ovf",     sif.ovf,  e_ovf);
         chk("done_id", sif.done_id, e_id);
      end
      prev_req  = sif.req;
      prev_rstn = rst_n;
   end

   // ---------------- stimulus ----------------
   task automatic run_op(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input logic scramble,
                         output logic [W-1:0] rs, output logic rc, output logic ro,
                         output int rid, output int lat);
      bit got;
      sif.a[idx*W +: W] = av;
      sif.b[idx*W +: W] = bv;
      sif.sub[idx]      = sv;
      sif.req[idx]      = 1'b1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         if (sif.gnt[idx]) got = 1;
      end
      chk("gnt_wait", got, 1);
      sif.req[idx] = 1'b0;
      lat = 0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         lat++;
         if (scramble) begin
            sif.a[idx*W +: W] = W'($urandom);
            sif.b[idx*W +: W] = W'($urandom);
            sif.sub[idx]      = ~sv;
         end
         if (sif.done) got = 1;
      end
      chk("done_wait", got, 1);
      rs  = sif.sum;
      rc  = sif.cout;
      ro  = sif.ovf;
      rid = int'(sif.done_id);
   endtask

   initial begin
      logic [W-1:0] rs;
      logic         rc, ro;
      int           rid, lat, gi;
      bit           got;
      int           exp_order [5];
      exp_order = '{0, 1, 2, 3, 0};

      sif.req = '0;
      sif.sub = '0;
      sif.a   = '0;
      sif.b   = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // signed overflow on add
      run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro, rid, lat);
      chk("t2_lat", lat, 9);
      chk("t2_sum", rs, 8'h80);
      chk("t2_cout", rc, 0);
      chk("t2_ovf", ro, 1);
      chk("t2_id", rid, 0);

      // subtraction: equal operands, then borrow
      run_op(0, 8'h33, 8'h33, 1'b1, 1'b0, rs, rc, ro, rid, lat);
      chk("t3_eq_sum", rs, 8'h00);
      chk("t3_eq_cout", rc, 1);
      chk("t3_eq_ovf", ro, 0);
      run_op(0, 8'h05, 8'h07, 1'b1, 1'b0, rs, rc, ro, rid, lat);
      chk("t3_sum", rs, 8'hFE);
      chk("t3_cout", rc, 0);
      chk("t3_ovf", ro, 0);

      // reset mid-SHIFT: op lost, outputs cleared, pointer back to 0
      sif.a[2*W +: W] = 8'h11;
      sif.b[2*W +: W] = 8'h22;
      sif.sub[2]      = 1'b0;
      sif.req         = 4'b0100;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         if (sif.gnt[2]) got = 1;
      end
      chk("t1_gnt_wait", got, 1);
      sif.req = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("t1_busy", sif.busy, 0);
      chk("t1_sum", sif.sum, 0);
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
         chk("t1_no_done", sif.done, 0);
      end
      sif.req = 4'b1010;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clk); #1;
         if (|sif.gnt) got = 1;
      end
      chk("t1_ptr_gnt", sif.gnt, 4'b0010);
      sif.req = '0;
      repeat (12) @(posedge clk);

      // all requesters held: round-robin order from pointer 0
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         sif.a[i*W +: W] = 8'hFF;
         sif.b[i*W +: W] = 8'h01;
      end
      sif.sub = '0;
      sif.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         got = 0;
         gi  = -1;
         for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (|sif.gnt) begin
               got = 1;
               for (int k = 0; k < NREQ; k++) if (sif.gnt[k]) gi = k;
            end
         end
         chk("t4_order", gi, exp_order[g]);
         if (g == 4) sif.req = '0;
         got = 0;
         for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (sif.done) got = 1;
         end
         chk("t4_done_wait", got, 1);
         chk("t4_sum", sif.sum, 8'h00);
         chk("t4_cout", sif.cout, 1);
         chk("t4_ovf", sif.ovf, 0);
         chk("t4_id", sif.done_id, exp_order[g]);
      end

      // operands scrambled during SHIFT
      run_op(1, 8'h10, 8'h20, 1'b0, 1'b1, rs, rc, ro, rid, lat);
      chk("t5_sum", rs, 8'h30);
      chk("t5_id", rid, 1);

      // random operations, checked by the model
      for (int n = 0; n < 150; n++) begin
         run_op(int'($urandom_range(0, NREQ-1)), W'($urandom), W'($urandom),
                1'($urandom), 1'b0, rs, rc, ro, rid, lat);
      end

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
